// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic-array feeder.
package systolic_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int N_ROWS     = 3;
    localparam int N_PHASES   = 4;
    localparam int PHASE_LEN  = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_SETTLE = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    typedef logic [1:0] phase_sel_t;

endpackage

// File: rtl/systolic_skew_gen.sv
// Diagonal skew window for one array row: passes the operand while the
// in-phase count sits in [K, K+N_ROWS-1], otherwise outputs zero.
module systolic_skew_gen #(
    parameter int DATA_W = 8,
    parameter int K      = 0
) (
    input  logic [2:0]        c,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] value
);
    import systolic_pkg::*;

    logic [3:0] rel_s;

    // Offset of the count from this row's window start; underflow wraps high.
    always_comb begin
        rel_s = {1'b0, c} - 4'(K);
        if (rel_s <= 4'(N_ROWS - 1)) begin
            value = operand;
        end else begin
            value = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Upstream sequencer for the 3x3-weight / 2x2-result systolic array.
// Latches one operand set on start, loads B weights, streams skewed A
// operands over four result phases and steps the result/c_reg selects.
// Optional build macro SYSTOLIC_FEEDER_REUSE_B_EN adds a reuse_b input that
// skips the weight load and keeps the previous B outputs.
module systolic_feeder #(
    parameter int DATA_W       = systolic_pkg::DEF_DATA_W,
    parameter int PHASE_LEN    = systolic_pkg::PHASE_LEN,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef SYSTOLIC_FEEDER_REUSE_B_EN
    input  logic                 reuse_b,
`endif
    input  logic [9*DATA_W-1:0]  b_data,
    input  logic [12*DATA_W-1:0] a_data,
    output logic                 busy,
    output logic                 done,
    output logic [8:0]           en_reg_B,
    output logic [DATA_W-1:0]    B11,
    output logic [DATA_W-1:0]    B12,
    output logic [DATA_W-1:0]    B13,
    output logic [DATA_W-1:0]    B21,
    output logic [DATA_W-1:0]    B22,
    output logic [DATA_W-1:0]    B23,
    output logic [DATA_W-1:0]    B31,
    output logic [DATA_W-1:0]    B32,
    output logic [DATA_W-1:0]    B33,
    output logic                 en_reg_A,
    output logic                 en_reg_Acc,
    output logic [DATA_W-1:0]    row1_in,
    output logic [DATA_W-1:0]    row2_in,
    output logic [DATA_W-1:0]    row3_in,
    output logic [1:0]           sel_en_demux_result,
    output logic [1:0]           sel_en_demux_c_reg,
    output logic                 input_demux_c_reg
);
    import systolic_pkg::*;

    localparam logic [2:0] C_LAST = 3'(PHASE_LEN - 1);
    localparam phase_sel_t P_LAST = 2'(N_PHASES - 1);
    localparam logic [7:0] D_LAST = 8'(DRAIN_CYCLES - 1);

    state_e                   state_r, state_s;
    phase_sel_t               p_r, p_s;
    logic [2:0]               c_r, c_s;
    logic [7:0]               drain_r, drain_s;
    logic                     accept_s, reuse_s, load_b_s;
    logic [11:0][DATA_W-1:0]  a_lat_r;
    logic [DATA_W-1:0]        skew_s [N_ROWS];
    logic [DATA_W-1:0]        row_s  [N_ROWS];
    logic                     busy_s, done_s, en_a_s, demux_s;
    logic [8:0]               en_b_s;
    phase_sel_t               sel_s;

`ifdef SYSTOLIC_FEEDER_REUSE_B_EN
    assign reuse_s = reuse_b;
`else
    assign reuse_s = 1'b0;
`endif

    assign load_b_s = accept_s & ~reuse_s;

    // Next-state and phase/count sequencing.
    always_comb begin
        state_s  = state_r;
        p_s      = p_r;
        c_s      = c_r;
        drain_s  = drain_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = reuse_s ? ST_SETTLE : ST_LOAD_B;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_LOAD_B: state_s = ST_SETTLE;
            ST_SETTLE: begin
                state_s = ST_STREAM;
                p_s     = 2'b00;
                c_s     = 3'd0;
            end
            ST_STREAM: begin
                if (c_r == C_LAST) begin
                    if (p_r == P_LAST) begin
                        state_s = ST_DRAIN;
                        drain_s = 8'd0;
                    end else begin
                        p_s = p_r + 2'd1;
                        c_s = 3'd0;
                    end
                end else begin
                    c_s = c_r + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_r == D_LAST) begin
                    state_s = ST_FIN;
                end else begin
                    drain_s = drain_r + 8'd1;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand source per row: element p*3+k of the latched A set.
    for (genvar k = 0; k < N_ROWS; k++) begin : g_row
        logic [3:0] idx_s;
        assign idx_s = 4'(p_s) * 4'(N_ROWS) + 4'(k);
        systolic_skew_gen #(
            .DATA_W (DATA_W),
            .K      (k)
        ) u_skew (
            .c       (c_s),
            .operand (a_lat_r[idx_s]),
            .value   (skew_s[k])
        );
    end

    // Output values for the upcoming state, registered below.
    always_comb begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        en_b_s  = 9'h000;
        en_a_s  = 1'b0;
        sel_s   = 2'b00;
        demux_s = accept_s ? 1'b1 : input_demux_c_reg;
        case (state_s)
            ST_IDLE:   busy_s = 1'b0;
            ST_LOAD_B: begin
                busy_s = 1'b1;
                en_b_s = 9'h1FF;
            end
            ST_SETTLE: begin
                busy_s = 1'b1;
                en_a_s = 1'b1;
            end
            ST_STREAM: begin
                busy_s = 1'b1;
                en_a_s = 1'b1;
                sel_s  = p_s;
            end
            ST_DRAIN: begin
                busy_s = 1'b1;
                en_a_s = 1'b1;
                sel_s  = 2'b11;
            end
            ST_FIN: begin
                done_s  = 1'b1;
                demux_s = 1'b0;
            end
            default: busy_s = 1'b0;
        endcase
        for (int k = 0; k < N_ROWS; k++) begin
            if (state_s == ST_STREAM) begin
                row_s[k] = skew_s[k];
            end else begin
                row_s[k] = {DATA_W{1'b0}};
            end
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            p_r     <= 2'b00;
            c_r     <= 3'd0;
            drain_r <= 8'd0;
        end else begin
            state_r <= state_s;
            p_r     <= p_s;
            c_r     <= c_s;
            drain_r <= drain_s;
        end
    end

    // Registered control and row outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy                <= 1'b0;
            done                <= 1'b0;
            en_reg_B            <= 9'h000;
            en_reg_A            <= 1'b0;
            en_reg_Acc          <= 1'b0;
            row1_in             <= {DATA_W{1'b0}};
            row2_in             <= {DATA_W{1'b0}};
            row3_in             <= {DATA_W{1'b0}};
            sel_en_demux_result <= 2'b00;
            sel_en_demux_c_reg  <= 2'b00;
            input_demux_c_reg   <= 1'b1;
        end else begin
            busy                <= busy_s;
            done                <= done_s;
            en_reg_B            <= en_b_s;
            en_reg_A            <= en_a_s;
            en_reg_Acc          <= 1'b0;
            row1_in             <= row_s[0];
            row2_in             <= row_s[1];
            row3_in             <= row_s[2];
            sel_en_demux_result <= sel_s;
            sel_en_demux_c_reg  <= sel_s;
            input_demux_c_reg   <= demux_s;
        end
    end

    // Operand capture at acceptance; B outputs double as the weight latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_lat_r <= '0;
            B11 <= {DATA_W{1'b0}};
            B12 <= {DATA_W{1'b0}};
            B13 <= {DATA_W{1'b0}};
            B21 <= {DATA_W{1'b0}};
            B22 <= {DATA_W{1'b0}};
            B23 <= {DATA_W{1'b0}};
            B31 <= {DATA_W{1'b0}};
            B32 <= {DATA_W{1'b0}};
            B33 <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                a_lat_r <= a_data;
            end
            if (load_b_s) begin
                B11 <= b_data[0*DATA_W +: DATA_W];
                B12 <= b_data[1*DATA_W +: DATA_W];
                B13 <= b_data[2*DATA_W +: DATA_W];
                B21 <= b_data[3*DATA_W +: DATA_W];
                B22 <= b_data[4*DATA_W +: DATA_W];
                B23 <= b_data[5*DATA_W +: DATA_W];
                B31 <= b_data[6*DATA_W +: DATA_W];
                B32 <= b_data[7*DATA_W +: DATA_W];
                B33 <= b_data[8*DATA_W +: DATA_W];
            end
        end
    end

endmodule
